// File: rtl/game_io_pkg.sv
// Shared types and constants for the game I/O blocks.
// Holds the event flasher state encoding and short sim timings.
package game_io_pkg;

  typedef enum logic [1:0] {
    FL_IDLE,
    FL_ON,
    FL_OFF
  } flash_state_e;

  localparam int SIM_ON_CYCLES  = 3;
  localparam int SIM_OFF_CYCLES = 2;

endpackage

// File: rtl/evt_flasher.sv
// Event flasher: turns single-cycle event pulses into LED blinks.
// Events arriving mid-blink are queued in a saturating counter.
module evt_flasher
  import game_io_pkg::*;
#(
  parameter int ON_CYCLES   = 25_000_000,
  parameter int OFF_CYCLES  = 12_500_000,
  parameter int MAX_PENDING = 3
) (
  input  logic                             CLOCK,
  input  logic                             reset_n,
  input  logic                             evt,
  output logic                             led,
  output logic                             busy,
  output logic [$clog2(MAX_PENDING+1)-1:0] pending,
  output logic                             drop
);

  localparam int MAXC = (ON_CYCLES > OFF_CYCLES) ?
                        ON_CYCLES : OFF_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int PW   = $clog2(MAX_PENDING + 1);

  localparam logic [CW-1:0] ON_LOAD  = CW'(ON_CYCLES - 1);
  localparam logic [CW-1:0] OFF_LOAD = CW'(OFF_CYCLES - 1);
  localparam logic [PW-1:0] PMAX     = PW'(MAX_PENDING);

  if (ON_CYCLES < 1) begin : g_bad_on
    $error("evt_flasher: ON_CYCLES must be >= 1");
  end
  if (OFF_CYCLES < 1) begin : g_bad_off
    $error("evt_flasher: OFF_CYCLES must be >= 1");
  end
  if (MAX_PENDING < 1) begin : g_bad_pend
    $error("evt_flasher: MAX_PENDING must be >= 1");
  end

  flash_state_e  state;
  flash_state_e  state_nx;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nx;
  logic [PW-1:0] pend_nx;
  logic          drop_nx;
  logic          cnt_zero;
  logic          pend_full;
  logic          pend_any;

  assign cnt_zero  = (cnt == '0);
  assign pend_full = (pending == PMAX);
  assign pend_any  = (pending != '0);

  // Next state, timer reload/decrement and queue update.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    pend_nx  = pending;
    drop_nx  = 1'b0;
    unique case (state)
      FL_IDLE: begin
        if (evt) begin
          state_nx = FL_ON;
          cnt_nx   = ON_LOAD;
        end
      end
      FL_ON: begin
        if (cnt_zero) begin
          state_nx = FL_OFF;
          cnt_nx   = OFF_LOAD;
        end else begin
          cnt_nx = cnt - 1'b1;
        end
        if (evt) begin
          if (pend_full) drop_nx = 1'b1;
          else pend_nx = pending + 1'b1;
        end
      end
      FL_OFF: begin
        if (cnt_zero) begin
          if (pend_any) begin
            state_nx = FL_ON;
            cnt_nx   = ON_LOAD;
            // a new event replaces the one taken off the queue
            if (!evt) pend_nx = pending - 1'b1;
          end else if (evt) begin
            state_nx = FL_ON;
            cnt_nx   = ON_LOAD;
          end else begin
            state_nx = FL_IDLE;
          end
        end else begin
          cnt_nx = cnt - 1'b1;
          if (evt) begin
            if (pend_full) drop_nx = 1'b1;
            else pend_nx = pending + 1'b1;
          end
        end
      end
      default: begin
        state_nx = FL_IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge CLOCK or negedge reset_n) begin
    if (!reset_n) state <= FL_IDLE;
    else          state <= state_nx;
  end

  // On/off timing down-counter.
  always_ff @(posedge CLOCK or negedge reset_n) begin
    if (!reset_n) cnt <= '0;
    else          cnt <= cnt_nx;
  end

  // Saturating queue of blinks still owed.
  always_ff @(posedge CLOCK or negedge reset_n) begin
    if (!reset_n) pending <= '0;
    else          pending <= pend_nx;
  end

  // Registered outputs derived from the next state.
  always_ff @(posedge CLOCK or negedge reset_n) begin
    if (!reset_n) begin
      led  <= 1'b0;
      busy <= 1'b0;
      drop <= 1'b0;
    end else begin
      led  <= (state_nx == FL_ON);
      busy <= (state_nx != FL_IDLE);
      drop <= drop_nx;
    end
  end

endmodule
